// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller and its
// hex decoder: FSM state encoding, "all dark" values and the segment table.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  // Active-low values that leave the display completely dark
  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns, entry i = hex digit i (F listed first)
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seven_seg_scan_ctrl_hex_to_7seg.sv
// Purely combinational hex nibble to active-low seven-segment decoder.
// Kept standalone so the single-digit static decoder can reuse it.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit time-multiplexed scan controller for a common-anode display.
// Each digit is lit for REFRESH_DIV cycles, followed by BLANK_CYC all-dark
// cycles. The digit values are frozen in a shadow register at frame start so
// a frame never shows a mix of old and new switch settings. Every output is
// registered from the next-state values, so it changes on the same edge as
// the state.
module seven_seg_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

  // Terminal counts; the gap terminal is unused when there is no dead-time
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST   =
    (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;

  scan_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       idx, idx_nx;
  logic [15:0]      shadow, shadow_nx;
  logic             tick_nx;
  logic [3:0]       anode_nx;
  logic             dp_nx;
  logic [6:0]       seg_nx;
  logic [3:0]       nibble_nx;
  logic [6:0]       seg_dec;

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble_nx),
    .seg    (seg_dec)
  );

  // Next-state logic: slot timing, digit advance and frame-start shadow load
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + CNT_W'(1);
    idx_nx    = idx;
    shadow_nx = shadow;
    tick_nx   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        idx_nx = 2'd0;
        if (enable) begin
          state_nx  = SHOW;
          shadow_nx = digits;
        end else begin
          state_nx  = IDLE;
        end
      end
      SHOW: begin
        if (!enable) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          idx_nx   = 2'd0;
        end else if (cnt == REFRESH_LAST) begin
          cnt_nx = '0;
          if (BLANK_CYC > 0) begin
            state_nx = GAP;
          end else begin
            state_nx = SHOW;
            idx_nx   = idx + 2'd1;
            if (idx == 2'd3) begin
              tick_nx   = 1'b1;
              shadow_nx = digits;
            end else begin
              tick_nx   = 1'b0;
            end
          end
        end else begin
          state_nx = SHOW;
        end
      end
      GAP: begin
        if (!enable) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          idx_nx   = 2'd0;
        end else if (cnt == BLANK_LAST) begin
          state_nx = SHOW;
          cnt_nx   = '0;
          idx_nx   = idx + 2'd1;
          if (idx == 2'd3) begin
            tick_nx   = 1'b1;
            shadow_nx = digits;
          end else begin
            tick_nx   = 1'b0;
          end
        end else begin
          state_nx = GAP;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        idx_nx   = 2'd0;
      end
    endcase
  end

  // Output decode from the next state; masks are sampled live, not shadowed
  always_comb begin
    anode_nx  = ANODE_OFF;
    dp_nx     = 1'b1;
    seg_nx    = SEG_OFF;
    nibble_nx = shadow_nx[{idx_nx, 2'b00} +: 4];
    if (state_nx == SHOW) begin
      seg_nx = seg_dec;
      dp_nx  = ~dp_mask[idx_nx];
      if (blank_mask[idx_nx]) begin
        anode_nx = ANODE_OFF;
      end else begin
        anode_nx = ~(4'b0001 << idx_nx);
      end
    end else begin
      seg_nx = SEG_OFF;
    end
  end

  // State, counter, shadow and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      anode      <= ANODE_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      shadow     <= shadow_nx;
      anode      <= anode_nx;
      seg        <= seg_nx;
      dp         <= dp_nx;
      frame_tick <= tick_nx;
    end
  end

  assign digit_idx = idx;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with REFRESH_DIV=4, BLANK_CYC=2,
// plus a second instance built with BLANK_CYC=0.
module tb_seven_seg_scan_ctrl;

  localparam int RD = 4;
  localparam int BC = 2;

  typedef struct {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
  } slot_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_mask;
  logic [3:0]  anode, anode_nb;
  logic [6:0]  seg, seg_nb;
  logic        dp, dp_nb;
  logic [1:0]  digit_idx, digit_idx_nb;
  logic        frame_tick, frame_tick_nb;

  int n_checks = 0;
  int n_fail   = 0;

  slot_exp_t tbl [5][4];
  slot_exp_t nb_tbl [4];

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .digits(digits),
    .blank_mask(blank_mask), .dp_mask(dp_mask), .anode(anode), .seg(seg),
    .dp(dp), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(0), .CNT_W(3)) dut_nb (
    .clk(clk), .rst(rst), .enable(enable), .digits(digits),
    .blank_mask(blank_mask), .dp_mask(dp_mask), .anode(anode_nb), .seg(seg_nb),
    .dp(dp_nb), .digit_idx(digit_idx_nb), .frame_tick(frame_tick_nb)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_main(input logic [3:0] a, input logic [6:0] s, input logic d,
                             input logic [1:0] i, input logic t);
    chk("anode", {12'h000, anode}, {12'h000, a});
    chk("seg", {9'h000, seg}, {9'h000, s});
    chk("dp", {15'h0000, dp}, {15'h0000, d});
    chk("digit_idx", {14'h0000, digit_idx}, {14'h0000, i});
    chk("frame_tick", {15'h0000, frame_tick}, {15'h0000, t});
  endtask

  task automatic expect_nb(input logic [3:0] a, input logic [6:0] s, input logic d,
                           input logic [1:0] i, input logic t);
    chk("nb_anode", {12'h000, anode_nb}, {12'h000, a});
    chk("nb_seg", {9'h000, seg_nb}, {9'h000, s});
    chk("nb_dp", {15'h0000, dp_nb}, {15'h0000, d});
    chk("nb_digit_idx", {14'h0000, digit_idx_nb}, {14'h0000, i});
    chk("nb_frame_tick", {15'h0000, frame_tick_nb}, {15'h0000, t});
  endtask

  // Cycles c_from..c_to of slot s; c < RD is the lit part, the rest is the gap
  task automatic run_cycles(input int f, input int s, input int c_from, input int c_to,
                            input logic first_tick);
    logic [1:0] si;
    si = s[1:0];
    for (int c = c_from; c <= c_to; c++) begin
      step();
      if (c < RD)
        expect_main(tbl[f][s].anode, tbl[f][s].seg, tbl[f][s].dp, si,
                    first_tick && (s == 0) && (c == 0));
      else
        expect_main(4'hF, 7'h7F, 1'b1, si, 1'b0);
    end
  endtask

  task automatic run_frame(input int f, input logic first_tick);
    for (int s = 0; s < 4; s++) run_cycles(f, s, 0, RD + BC - 1, first_tick);
  endtask

  initial begin
    // frame 0: digits 3A0F, no masks
    tbl[0][0] = '{4'hE, 7'h0E, 1'b1}; tbl[0][1] = '{4'hD, 7'h40, 1'b1};
    tbl[0][2] = '{4'hB, 7'h08, 1'b1}; tbl[0][3] = '{4'h7, 7'h30, 1'b1};
    // frame 1: digits 1111
    tbl[1][0] = '{4'hE, 7'h79, 1'b1}; tbl[1][1] = '{4'hD, 7'h79, 1'b1};
    tbl[1][2] = '{4'hB, 7'h79, 1'b1}; tbl[1][3] = '{4'h7, 7'h79, 1'b1};
    // frame 2: blank_mask=0100, dp_mask=0001
    tbl[2][0] = '{4'hE, 7'h79, 1'b0}; tbl[2][1] = '{4'hD, 7'h79, 1'b1};
    tbl[2][2] = '{4'hF, 7'h79, 1'b1}; tbl[2][3] = '{4'h7, 7'h79, 1'b1};
    // frame 3: digits 1111 again, masks cleared
    tbl[3][0] = '{4'hE, 7'h79, 1'b1}; tbl[3][1] = '{4'hD, 7'h79, 1'b1};
    tbl[3][2] = '{4'hB, 7'h79, 1'b1}; tbl[3][3] = '{4'h7, 7'h79, 1'b1};
    // frame 4: digits d6C2 after restart
    tbl[4][0] = '{4'hE, 7'h24, 1'b1}; tbl[4][1] = '{4'hD, 7'h46, 1'b1};
    tbl[4][2] = '{4'hB, 7'h02, 1'b1}; tbl[4][3] = '{4'h7, 7'h21, 1'b1};
    // no-gap build: digits 8421
    nb_tbl[0] = '{4'hE, 7'h79, 1'b1}; nb_tbl[1] = '{4'hD, 7'h24, 1'b1};
    nb_tbl[2] = '{4'hB, 7'h19, 1'b1}; nb_tbl[3] = '{4'h7, 7'h00, 1'b1};

    rst = 1'b1; enable = 1'b1; digits = 16'h3A0F;
    blank_mask = 4'b0000; dp_mask = 4'b0000;

    // reset held with enable high: dark throughout
    for (int k = 0; k < 3; k++) begin
      step();
      expect_main(4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
    end
    rst = 1'b0;

    // frame 0, digits change to 1111 during slot 1 (must stay invisible)
    run_cycles(0, 0, 0, RD + BC - 1, 1'b0);
    run_cycles(0, 1, 0, 0, 1'b0);
    digits = 16'h1111;
    run_cycles(0, 1, 1, RD + BC - 1, 1'b0);
    run_cycles(0, 2, 0, RD + BC - 1, 1'b0);
    run_cycles(0, 3, 0, RD + BC - 1, 1'b0);

    // frame 1 shows the new value everywhere
    run_frame(1, 1'b1);

    // frame 2 with live masks
    blank_mask = 4'b0100; dp_mask = 4'b0001;
    run_frame(2, 1'b1);
    blank_mask = 4'b0000; dp_mask = 4'b0000;

    // frame 3: drop enable mid slot 2
    run_cycles(3, 0, 0, RD + BC - 1, 1'b1);
    run_cycles(3, 1, 0, RD + BC - 1, 1'b0);
    run_cycles(3, 2, 0, 1, 1'b0);
    enable = 1'b0;
    digits = 16'hD6C2;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_main(4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
    end
    enable = 1'b1;

    // restart at slot 0 with re-latched digits, no tick on restart
    run_frame(4, 1'b0);
    run_cycles(4, 0, 0, 1, 1'b1);

    // reset mid-slot: dark on the next edge although enable stays high
    rst = 1'b1;
    digits = 16'h8421;
    step();
    expect_main(4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
    expect_nb(4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
    rst = 1'b0;

    // no-gap build: 16-cycle frames, one anode low every cycle
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < RD; c++) begin
          step();
          expect_nb(nb_tbl[s].anode, nb_tbl[s].seg, nb_tbl[s].dp, s[1:0],
                    (f == 1) && (s == 0) && (c == 0));
        end
      end
    end
    step();
    expect_nb(nb_tbl[0].anode, nb_tbl[0].seg, nb_tbl[0].dp, 2'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
